// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank port between NumReq requesters.
// A fixed-depth ID pipeline routes each bank response back to its issuer.
module tcdm_bank_arbiter #(
   parameter  int unsigned NumReq    = 4,
   parameter  int unsigned AddrWidth = 11,
   parameter  int unsigned DataWidth = 64,
   parameter  int unsigned BeWidth   = DataWidth / 8,
   parameter  int unsigned RespLat   = 1,
   localparam int unsigned IdWidth   = $clog2(NumReq)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_valid_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
   input  logic [NumReq-1:0]             req_write_i,
   input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
   input  logic [NumReq*BeWidth-1:0]     req_strb_i,
   output logic [NumReq-1:0]             rsp_valid_o,
   output logic [DataWidth-1:0]          rsp_rdata_o,
   output logic                          mem_req_o,
   input  logic                          mem_gnt_i,
   output logic [AddrWidth-1:0]          mem_addr_o,
   output logic                          mem_we_o,
   output logic [DataWidth-1:0]          mem_wdata_o,
   output logic [BeWidth-1:0]            mem_be_o,
   input  logic [DataWidth-1:0]          mem_rdata_i
);

   localparam int unsigned PipeW = RespLat * IdWidth;

   logic [IdWidth-1:0]              r_rr;
   logic [RespLat-1:0]              r_vld;
   logic [RespLat-1:0][IdWidth-1:0] r_id;

   logic [IdWidth-1:0]              w_win;
   logic [IdWidth-1:0]              w_idx;
   logic                            w_any;
   logic                            w_xfer;

   // Scan from the priority pointer upwards, wrapping at NumReq.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         w_idx = IdWidth'((32'(r_rr) + i) % NumReq);
         if (!w_any && req_valid_i[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
   end

   assign w_xfer    = w_any & mem_gnt_i;
   assign mem_req_o = w_any;

   always_comb begin
      req_ready_o = '0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (w_any && (w_win == IdWidth'(k))) begin
            req_ready_o[k] = mem_gnt_i;
            mem_addr_o     = req_addr_i[k*AddrWidth +: AddrWidth];
            mem_we_o       = req_write_i[k];
            mem_wdata_o    = req_wdata_i[k*DataWidth +: DataWidth];
            mem_be_o       = req_strb_i[k*BeWidth +: BeWidth];
         end
      end
   end

   // The pipeline never stalls: stage 0 captures every cycle, older stages shift.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rr  <= '0;
         r_vld <= '0;
         r_id  <= '0;
      end else begin
         if (w_xfer) begin
            r_rr <= (w_win == IdWidth'(NumReq - 1)) ? '0 : w_win + 1'b1;
         end
         r_vld <= RespLat'({r_vld, w_xfer});
         r_id  <= PipeW'({r_id, w_win});
      end
   end

   always_comb begin
      rsp_valid_o = '0;
      if (r_vld[RespLat-1]) begin
         rsp_valid_o[r_id[RespLat-1]] = 1'b1;
      end
   end

   assign rsp_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter: RespLat=1 and RespLat=3 instances share stimulus
// and are compared every cycle against a transaction-level model.
module tb_tcdm_bank_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    valid, we;
   logic [43:0]   addr;
   logic [255:0]  wdata;
   logic [31:0]   strb;
   logic          gnt;

   logic [3:0]    r1_ready, r1_rsp, r3_ready, r3_rsp;
   logic [63:0]   r1_rdata, r3_rdata, m1_wdata, m3_wdata, m1_rdata, m3_rdata;
   logic          m1_req, m3_req, m1_we, m3_we;
   logic [10:0]   m1_addr, m3_addr;
   logic [7:0]    m1_be, m3_be;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   tcdm_bank_arbiter #(.RespLat(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(r1_ready),
      .req_addr_i(addr), .req_write_i(we), .req_wdata_i(wdata), .req_strb_i(strb),
      .rsp_valid_o(r1_rsp), .rsp_rdata_o(r1_rdata), .mem_req_o(m1_req), .mem_gnt_i(gnt),
      .mem_addr_o(m1_addr), .mem_we_o(m1_we), .mem_wdata_o(m1_wdata), .mem_be_o(m1_be),
      .mem_rdata_i(m1_rdata));

   tcdm_bank_arbiter #(.RespLat(3)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(r3_ready),
      .req_addr_i(addr), .req_write_i(we), .req_wdata_i(wdata), .req_strb_i(strb),
      .rsp_valid_o(r3_rsp), .rsp_rdata_o(r3_rdata), .mem_req_o(m3_req), .mem_gnt_i(gnt),
      .mem_addr_o(m3_addr), .mem_we_o(m3_we), .mem_wdata_o(m3_wdata), .mem_be_o(m3_be),
      .mem_rdata_i(m3_rdata));

   function automatic logic [63:0] merge(input logic [63:0] old_d, input logic [63:0] new_d,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old_d;
      for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Bank models: one per instance, driven by that instance's memory port.
   logic [63:0] bank1 [32];
   logic [63:0] bank3 [32];
   logic [63:0] p1;
   logic [63:0] p3 [3];

   initial begin
      for (int i = 0; i < 32; i++) begin bank1[i] = '0; bank3[i] = '0; end
      p1 = '0;
      for (int i = 0; i < 3; i++) p3[i] = '0;
   end

   always @(posedge clk) begin
      p1 <= '0;
      if (m1_req && gnt) begin
         if (m1_we) bank1[m1_addr[4:0]] <= merge(bank1[m1_addr[4:0]], m1_wdata, m1_be);
         else       p1 <= bank1[m1_addr[4:0]];
      end
      p3[0] <= '0;
      if (m3_req && gnt) begin
         if (m3_we) bank3[m3_addr[4:0]] <= merge(bank3[m3_addr[4:0]], m3_wdata, m3_be);
         else       p3[0] <= bank3[m3_addr[4:0]];
      end
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   assign m1_rdata = p1;
   assign m3_rdata = p3[2];

   // Transaction-level reference model and per-cycle comparison.
   typedef struct {
      int          due;
      int          id;
      bit          rd;
      logic [63:0] data;
   } rsp_t;

   rsp_t q1[$];
   rsp_t q3[$];

   task automatic chk_req(input string tag, input logic [3:0] rdy, input logic req,
                          input logic [10:0] a, input logic w, input logic [63:0] d,
                          input logic [7:0] be, input logic [3:0] e_rdy, input logic e_req,
                          input logic [10:0] e_a, input logic e_w, input logic [63:0] e_d,
                          input logic [7:0] e_be);
      chk({tag, "_ready"}, 64'(rdy), 64'(e_rdy));
      chk({tag, "_mreq"},  64'(req), 64'(e_req));
      chk({tag, "_addr"},  64'(a),   64'(e_a));
      chk({tag, "_we"},    64'(w),   64'(e_w));
      chk({tag, "_wdata"}, d,        e_d);
      chk({tag, "_be"},    64'(be),  64'(e_be));
   endtask

   task automatic chk_rsp(input string tag, input logic [3:0] rsp, input logic [63:0] rdata,
                          input int cyc, inout rsp_t q[$]);
      logic [3:0] e_rsp;
      e_rsp = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e_rsp[q[0].id] = 1'b1;
         if (q[0].rd) chk({tag, "_rdata"}, rdata, q[0].data);
         void'(q.pop_front());
      end
      chk({tag, "_rsp"}, 64'(rsp), 64'(e_rsp));
   endtask

   initial begin
      int          m_rr;
      int          cyc;
      int          win;
      logic [63:0] mmem [32];
      logic [3:0]  e_rdy;
      logic [10:0] e_a;
      logic        e_w;
      logic [63:0] e_d, rdv;
      logic [7:0]  e_be;
      m_rr = 0;
      cyc  = 0;
      for (int i = 0; i < 32; i++) mmem[i] = '0;
      forever begin
         @(negedge clk);
         win = -1;
         for (int i = 0; i < 4; i++) begin
            if (win < 0 && valid[(m_rr + i) % 4]) win = (m_rr + i) % 4;
         end
         e_rdy = '0; e_a = '0; e_w = 1'b0; e_d = '0; e_be = '0;
         if (win >= 0) begin
            if (gnt) e_rdy[win] = 1'b1;
            e_a  = addr[win*11 +: 11];
            e_w  = we[win];
            e_d  = wdata[win*64 +: 64];
            e_be = strb[win*8 +: 8];
         end
         chk_req("l1", r1_ready, m1_req, m1_addr, m1_we, m1_wdata, m1_be,
                 e_rdy, win >= 0, e_a, e_w, e_d, e_be);
         chk_req("l3", r3_ready, m3_req, m3_addr, m3_we, m3_wdata, m3_be,
                 e_rdy, win >= 0, e_a, e_w, e_d, e_be);
         chk_rsp("l1", r1_rsp, r1_rdata, cyc, q1);
         chk_rsp("l3", r3_rsp, r3_rdata, cyc, q3);

         rdv = '0;
         if (win >= 0 && gnt) begin
            rdv = mmem[e_a[4:0]];
            if (e_w) mmem[e_a[4:0]] = merge(mmem[e_a[4:0]], e_d, e_be);
         end
         if (!rst_n) begin
            m_rr = 0;
            q1.delete();
            q3.delete();
         end else if (win >= 0 && gnt) begin
            m_rr = (win + 1) % 4;
            q1.push_back('{due: cyc + 1, id: win, rd: !e_w, data: rdv});
            q3.push_back('{due: cyc + 3, id: win, rd: !e_w, data: rdv});
         end
         cyc++;
      end
   end

   // Stimulus with literal expectations for the directed scenarios.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic v, input logic [10:0] a, input logic w,
                          input logic [63:0] d, input logic [7:0] s);
      valid[k]           = v;
      addr[k*11 +: 11]   = a;
      we[k]              = w;
      wdata[k*64 +: 64]  = d;
      strb[k*8 +: 8]     = s;
   endtask

   initial begin
      logic [63:0] lit5 [3];
      logic [3:0]  g;
      lit5[0] = 64'h1111_2222_3333_4444;
      lit5[1] = 64'h5555_6666_7777_8888;
      lit5[2] = 64'h9999_AAAA_BBBB_CCCC;
      rst_n = 1'b0; valid = '0; we = '0; addr = '0; wdata = '0; strb = '0; gnt = 1'b1;
      tick(); tick();
      rst_n = 1'b1;

      // Single requester write then read.
      tick(); set_req(0, 1'b1, 11'h010, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hFF);
      @(negedge clk); chk("t1_wr_ready", 64'(r1_ready), 64'h1); chk("t1_wr_we", 64'(m1_we), 64'h1);
      tick(); set_req(0, 1'b1, 11'h010, 1'b0, '0, 8'h00);
      @(negedge clk); chk("t1_rd_ready", 64'(r1_ready), 64'h1); chk("t1_rd_we", 64'(m1_we), 64'h0);
      chk("t1_wr_ack", 64'(r1_rsp), 64'h1);
      tick(); valid = '0;
      @(negedge clk); chk("t1_rd_rsp", 64'(r1_rsp), 64'h1);
      chk("t1_rd_data", r1_rdata, 64'hDEADBEEF_CAFEF00D);

      // All four continuously valid from rr=0.
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_req(k, 1'b1, 11'(k + 20), 1'b0, '0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_grant", 64'(r1_ready), 64'(4'b0001 << (i % 4)));
         if (i > 0) chk("t2_rsp_id", 64'(r1_rsp), 64'(4'b0001 << ((i - 1) % 4)));
         tick();
      end
      valid = '0;
      @(negedge clk); chk("t2_rsp_last", 64'(r1_rsp), 64'h8);

      // Wrap from rr=2: requester 3 before 1.
      tick(); valid = 4'b0010;
      @(negedge clk); chk("t3_setup", 64'(r1_ready), 64'h2);
      tick(); valid = 4'b1010;
      @(negedge clk); chk("t3_first", 64'(r1_ready), 64'h8);
      tick();
      @(negedge clk); chk("t3_second", 64'(r1_ready), 64'h2);
      tick(); valid = 4'b1111;
      @(negedge clk); chk("t3_rr_is_2", 64'(r1_ready), 64'h4);

      // Bank stall with requester 2 waiting.
      tick(); valid = '0;
      tick(); set_req(2, 1'b1, 11'd7, 1'b0, '0, 8'h00); gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_stall_ready", 64'(r1_ready), 64'h0);
         chk("t4_stall_addr", 64'(m1_addr), 64'd7);
         chk("t4_stall_rsp", 64'(r1_rsp), 64'h0);
         tick();
      end
      gnt = 1'b1;
      @(negedge clk); chk("t4_grant", 64'(r1_ready), 64'h4); chk("t4_addr", 64'(m1_addr), 64'd7);
      tick(); valid = '0;

      // RespLat=3 back-to-back reads.
      for (int i = 0; i < 3; i++) begin
         tick(); set_req(0, 1'b1, 11'(i + 1), 1'b1, lit5[i], 8'hFF);
      end
      for (int i = 0; i < 3; i++) begin
         tick(); set_req(0, 1'b1, 11'(i + 1), 1'b0, '0, 8'h00);
      end
      tick(); valid = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_rsp", 64'(r3_rsp), 64'h1);
         chk("t5_data", r3_rdata, lit5[i]);
         tick();
      end

      // Reset with two reads in flight.
      set_req(0, 1'b1, 11'd1, 1'b0, '0, 8'h00);
      tick(); set_req(0, 1'b1, 11'd2, 1'b0, '0, 8'h00);
      tick(); rst_n = 1'b0; valid = '0;
      tick(); rst_n = 1'b1; valid = 4'b1010;
      @(negedge clk); chk("t6_lowest", 64'(r1_ready), 64'h2); chk("t6_rsp", 64'(r3_rsp), 64'h0);
      tick(); valid = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); chk("t6_rsp", 64'(r3_rsp), 64'h0);
         tick();
      end

      // Randomized traffic; a requester holds its request until granted.
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         g = r1_ready;
         tick();
         rst_n = ($urandom_range(0, 99) != 0);
         gnt   = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 4; k++) begin
            if (!(valid[k] && !g[k])) begin
               set_req(k, $urandom_range(0, 2) != 0, 11'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom));
            end
         end
      end
      tick(); valid = '0; rst_n = 1'b1;
      tick(); tick(); tick(); tick();
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Round-robin arbiter that shares one TCDM memory bank port between NumReq narrow requesters.
- Sits between the master side (core/DMA/Ising-engine ports) and a single SRAM bank behind tcdm_interconnect_wrap.
- Tracks in-flight transactions in a RespLat-deep ID pipeline and routes each bank response back to the requester that issued it.

Parameters:
- NumReq, 4, number of requesters (>=2).
- AddrWidth, 11, bank word-address width.
- DataWidth, 64, data width.
- BeWidth, DataWidth/8, byte-enable width.
- RespLat, 1, fixed bank read latency in cycles (>=1).
- IdWidth, $clog2(NumReq), derived; not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester grant (one-hot or zero).
- req_addr_i  in  NumReq*AddrWidth  packed addresses; requester k at [k*AddrWidth +: AddrWidth].
- req_write_i  in  NumReq  1 = write, 0 = read.
- req_wdata_i  in  NumReq*DataWidth  packed write data.
- req_strb_i  in  NumReq*BeWidth  packed byte enables.
- rsp_valid_o  out  NumReq  per-requester response strobe.
- rsp_rdata_o  out  DataWidth  read data, shared by all requesters.
- mem_req_o  out  1  bank request.
- mem_gnt_i  in  1  bank grant.
- mem_addr_o  out  AddrWidth  bank address.
- mem_we_o  out  1  bank write enable.
- mem_wdata_o  out  DataWidth  bank write data.
- mem_be_o  out  BeWidth  bank byte enables.
- mem_rdata_i  in  DataWidth  bank read data, valid RespLat cycles after an accepted request.

Behaviour:
- Reset (rst_ni low at posedge):
  - priority pointer rr_q <= 0.
  - ID pipeline valid bits <= 0; in-flight responses are dropped, never delivered.
  - rsp_valid_o = 0 from the cycle after reset asserts.
  - Request-side outputs are combinational; with all req_valid_i=0 they read 0.
- Arbitration (combinational):
  - Winner w = first k with req_valid_i[k]=1, scanning rr_q, rr_q+1, ... mod NumReq.
  - mem_req_o = |req_valid_i.
  - mem_addr_o/we/wdata/be driven from requester w; all zero when no valid.
- Handshake:
  - req_ready_o[w] = mem_gnt_i & mem_req_o; all other ready bits 0.
  - Transfer occurs when valid & ready are both 1 in the same cycle.
  - Requester holds addr/data/write/strb stable while valid & !ready.
  - Arbiter never deasserts a request on its own; the winner may change between cycles if mem_gnt_i=0. No lock is held across stalls.
- Pointer update: on transfer, rr_q <= (w+1) mod NumReq; otherwise it holds.
- Fairness: a continuously-valid requester is granted within NumReq-1 transfers by others.
- Response pipeline:
  - RespLat stages of {vld, id}. Stage 0 loads {transfer, w}; each stage shifts every cycle, with no stall.
  - Every accepted request, read or write, yields rsp_valid_o[id]=1 for exactly one cycle, RespLat cycles after the transfer cycle.
  - rsp_rdata_o = mem_rdata_i, passthrough. Meaningful only for reads; for writes the strobe is an acknowledge.
  - Back-to-back transfers give back-to-back responses in issue order. At most one rsp_valid_o bit is set per cycle.
- Boundaries:
  - Single valid requester: granted every cycle mem_gnt_i=1 (full throughput).
  - rr_q wrap: from NumReq-1 it wraps to 0.
  - mem_gnt_i=0: no transfer, pointer and pipeline stage 0 valid unchanged/0.
  - Reset mid-burst: pending pipeline responses are discarded. The first post-reset transfer goes to the lowest valid index.

Test Plan:
- Single requester 0 writes addr 0x010 data 0xDEADBEEF_CAFEF00D strb 0xFF, then reads 0x010. Expect: req_ready_o=0001 both cycles, mem_we_o 1 then 0, rsp_valid_o[0] at t+1 and t+2 (RespLat=1), rdata 0xDEADBEEF_CAFEF00D from the bank model.
- All 4 requesters valid continuously, mem_gnt_i=1, 8 cycles. Expect grant order 0,1,2,3,0,1,2,3 and response IDs in the same order, each 1 cycle later.
- Requesters 1 and 3 valid with rr_q=2. Expect 3 granted first, then 1 (wrap). rr_q ends at 2.
- mem_gnt_i=0 for 3 cycles with requester 2 valid. Expect req_ready_o=0, rr_q unchanged, no rsp_valid_o. On gnt=1, requester 2 is granted with stable addr.
- RespLat=3 build: 3 back-to-back reads from requester 0 to addr 1,2,3. Expect rsp_valid_o[0] on cycles t+3..t+5 with data of addr 1,2,3 in order.
- Assert rst_ni=0 for 1 cycle with 2 reads in flight (RespLat=3). Expect no rsp_valid_o afterwards, rr_q=0, next grant to the lowest valid index.
